// File: rtl/regfile_sb.sv
// Multi-port register file with busy-bit scoreboard (reg 0 hard-wired zero, never busy).
// Optional macro REGFILE_BYPASS_EN: forward same-cycle write-back data/readiness to read ports.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 64,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rready,
  input  logic                rsv_valid,
  input  logic [AW-1:0]       rsv_addr,
  output logic                rsv_stall,
  input  logic [NWR-1:0]      wb_valid,
  input  logic [NWR*AW-1:0]   wb_addr,
  input  logic [NWR*XLEN-1:0] wb_data,
  input  logic                flush,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [AW:0]     r_busy_cnt;

  logic [NREG-1:0] w_wen;
  logic [XLEN-1:0] w_wdata [NREG];
  logic            w_rsv_req;
  logic            w_stall;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_busy_nxt;
  logic [AW:0]     w_cnt_nxt;

  // Write-back decode: ascending port order so the highest port index wins data.
  always_comb begin
    w_wen = '0;
    for (int r = 0; r < NREG; r++) w_wdata[r] = '0;
    for (int p = 0; p < NWR; p++) begin
      if (wb_valid[p] && (wb_addr[p*AW +: AW] != '0)) begin
        w_wen[wb_addr[p*AW +: AW]]   = 1'b1;
        w_wdata[wb_addr[p*AW +: AW]] = wb_data[p*XLEN +: XLEN];
      end else begin
      end
    end
  end

  // Reservation acceptance; a busy target is still granted if a write-back frees it now.
  always_comb begin
    w_rsv_req = rsv_valid && !flush && (rsv_addr != '0);
    w_stall   = w_rsv_req && r_busy[rsv_addr] && !w_wen[rsv_addr];
    w_set     = '0;
    if (w_rsv_req && !w_stall) begin
      w_set[rsv_addr] = 1'b1;
    end else begin
      w_set = '0;
    end
  end

  // Next busy vector; the counter is the exact popcount of it, so merged events net out.
  always_comb begin
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      w_busy_nxt = (r_busy & ~w_wen) | w_set;
    end
    w_cnt_nxt = '0;
    for (int r = 0; r < NREG; r++) w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[r]};
  end

  // Register storage; entry 0 never receives a write enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NREG; r++) r_regs[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (w_wen[r]) r_regs[r] <= w_wdata[r];
        else          r_regs[r] <= r_regs[r];
      end
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  // Combinational read ports with optional write-back forwarding.
  always_comb begin
    rdata  = '0;
    rready = '1;
    for (int k = 0; k < NRD; k++) begin
      if (raddr[k*AW +: AW] == '0) begin
        rdata[k*XLEN +: XLEN] = '0;
        rready[k]             = 1'b1;
      end else begin
        rdata[k*XLEN +: XLEN] = r_regs[raddr[k*AW +: AW]];
        rready[k]             = !r_busy[raddr[k*AW +: AW]];
      end
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NWR; p++) begin
        if (wb_valid[p] && (wb_addr[p*AW +: AW] != '0) &&
            (wb_addr[p*AW +: AW] == raddr[k*AW +: AW])) begin
          rdata[k*XLEN +: XLEN] = wb_data[p*XLEN +: XLEN];
          rready[k]             = 1'b1;
        end else begin
        end
      end
`else
`endif
    end
  end

  assign rsv_stall = w_stall;
  assign busy_cnt  = r_busy_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters, either bypass build).
module tb_regfile_sb;
  localparam int AW = 6;

  logic        clk = 1'b0;
  logic        rstn;
  logic [5:0]  ra0, ra1;
  logic [63:0] rdata;
  logic [1:0]  rready;
  logic        rsv_valid;
  logic [5:0]  rsv_addr;
  logic        rsv_stall;
  logic [1:0]  wb_valid;
  logic [5:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic        flush;
  logic [6:0]  busy_cnt;

  int n_total = 0;
  int n_bad   = 0;

  regfile_sb dut (
    .clk      (clk),
    .rstn     (rstn),
    .raddr    ({ra1, ra0}),
    .rdata    (rdata),
    .rready   (rready),
    .rsv_valid(rsv_valid),
    .rsv_addr (rsv_addr),
    .rsv_stall(rsv_stall),
    .wb_valid (wb_valid),
    .wb_addr  ({wa1, wa0}),
    .wb_data  ({wd1, wd0}),
    .flush    (flush),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rsv_valid = 1'b0; rsv_addr = 6'd0; wb_valid = 2'b00;
    wa0 = 6'd0; wa1 = 6'd0; wd0 = 32'd0; wd1 = 32'd0; flush = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; ra0 = 6'd5; ra1 = 6'd9;
    idle();
    #12;
    chk("rst_rdata", {32'd0, rdata}, 64'd0);
    chk("rst_rready", {62'd0, rready}, {62'd0, 2'b11});
    chk("rst_cnt", {57'd0, busy_cnt}, 64'd0);
    chk("rst_stall", {63'd0, rsv_stall}, 64'd0);
    rstn = 1'b1;
    tick();

    // Basic write then read
    wb_valid = 2'b01; wa0 = 6'd5; wd0 = 32'hDEADBEEF;
    tick(); idle(); ra0 = 6'd5;
    #1 chk("wr_r5", {32'd0, rdata[31:0]}, {32'd0, 32'hDEADBEEF});

    // Write to r0 ignored; reserve r0 accepted without effect
    wb_valid = 2'b01; wa0 = 6'd0; wd0 = 32'h1234;
    tick(); idle(); ra0 = 6'd0;
    #1 chk("r0_zero", {32'd0, rdata[31:0]}, 64'd0);
    chk("r0_cnt", {57'd0, busy_cnt}, 64'd0);
    rsv_valid = 1'b1; rsv_addr = 6'd0;
    #1 chk("rsv_r0_stall", {63'd0, rsv_stall}, 64'd0);
    tick(); idle(); ra1 = 6'd0;
    #1 chk("rsv_r0_ready", {63'd0, rready[1]}, 64'd1);
    chk("rsv_r0_cnt", {57'd0, busy_cnt}, 64'd0);

    // Reserve r7, then WAW stall
    rsv_valid = 1'b1; rsv_addr = 6'd7;
    #1 chk("rsv_r7_nostall", {63'd0, rsv_stall}, 64'd0);
    tick(); idle(); ra0 = 6'd7;
    #1 chk("r7_notready", {63'd0, rready[0]}, 64'd0);
    chk("r7_cnt1", {57'd0, busy_cnt}, 64'd1);
    rsv_valid = 1'b1; rsv_addr = 6'd7;
    #1 chk("r7_waw_stall", {63'd0, rsv_stall}, 64'd1);
    tick(); idle();
    #1 chk("r7_cnt_still1", {57'd0, busy_cnt}, 64'd1);

    // Write-back to r7 on port 1
    wb_valid = 2'b10; wa1 = 6'd7; wd1 = 32'hA5;
`ifdef REGFILE_BYPASS_EN
    #1 chk("r7_byp_data", {32'd0, rdata[31:0]}, 64'hA5);
    chk("r7_byp_ready", {63'd0, rready[0]}, 64'd1);
`else
    #1 chk("r7_nobyp_data", {32'd0, rdata[31:0]}, 64'd0);
    chk("r7_nobyp_ready", {63'd0, rready[0]}, 64'd0);
`endif
    tick(); idle();
    #1 chk("r7_data", {32'd0, rdata[31:0]}, 64'hA5);
    chk("r7_ready", {63'd0, rready[0]}, 64'd1);
    chk("r7_cnt0", {57'd0, busy_cnt}, 64'd0);

    // Same address on both ports: port 1 wins; distinct addresses both land
    wb_valid = 2'b11; wa0 = 6'd3; wd0 = 32'h11; wa1 = 6'd3; wd1 = 32'h22;
    tick(); idle(); ra1 = 6'd3;
    #1 chk("r3_port1_wins", {32'd0, rdata[63:32]}, 64'h22);
    wb_valid = 2'b11; wa0 = 6'd10; wd0 = 32'hAAAA; wa1 = 6'd11; wd1 = 32'hBBBB;
    tick(); idle(); ra0 = 6'd10; ra1 = 6'd11;
    #1 chk("r10_r11", {rdata[63:32], rdata[31:0]}, {32'hBBBB, 32'hAAAA});

    // Reserve and write-back same register same cycle
    rsv_valid = 1'b1; rsv_addr = 6'd9; wb_valid = 2'b01; wa0 = 6'd9; wd0 = 32'h55;
    tick(); idle(); ra0 = 6'd9;
    #1 chk("r9_data", {32'd0, rdata[31:0]}, 64'h55);
    chk("r9_busy", {63'd0, rready[0]}, 64'd0);
    chk("r9_cnt", {57'd0, busy_cnt}, 64'd1);
    // Busy r9 re-reserved while a write-back frees it: granted, stays busy once
    rsv_valid = 1'b1; rsv_addr = 6'd9; wb_valid = 2'b01; wa0 = 6'd9; wd0 = 32'h66;
    #1 chk("r9_rereserve_nostall", {63'd0, rsv_stall}, 64'd0);
    tick(); idle();
    #1 chk("r9_data2", {32'd0, rdata[31:0]}, 64'h66);
    chk("r9_still_busy", {63'd0, rready[0]}, 64'd0);
    chk("r9_cnt_once", {57'd0, busy_cnt}, 64'd1);
    wb_valid = 2'b01; wa0 = 6'd9; wd0 = 32'h77;
    tick(); idle();
    #1 chk("r9_freed_cnt", {57'd0, busy_cnt}, 64'd0);

    // Fill three, then double write-back to one busy register counts once
    rsv_valid = 1'b1; rsv_addr = 6'd1; tick();
    rsv_addr = 6'd2; tick();
    rsv_addr = 6'd40; tick(); idle();
    #1 chk("cnt3", {57'd0, busy_cnt}, 64'd3);
    wb_valid = 2'b11; wa0 = 6'd1; wd0 = 32'h1; wa1 = 6'd1; wd1 = 32'h2;
    tick(); idle();
    #1 chk("cnt_dup_wb", {57'd0, busy_cnt}, 64'd2);

    // Flush with reservation request and concurrent write-back
    flush = 1'b1; rsv_valid = 1'b1; rsv_addr = 6'd40;
    wb_valid = 2'b01; wa0 = 6'd12; wd0 = 32'hC0DE;
    #1 chk("flush_nostall", {63'd0, rsv_stall}, 64'd0);
    rsv_addr = 6'd4;
    tick(); idle(); ra0 = 6'd4; ra1 = 6'd2;
    #1 chk("flush_cnt", {57'd0, busy_cnt}, 64'd0);
    chk("flush_ready", {62'd0, rready}, {62'd0, 2'b11});
    ra1 = 6'd12;
    #1 chk("flush_wb_kept", {32'd0, rdata[63:32]}, 64'hC0DE);

    // Asynchronous reset mid-operation
    rsv_valid = 1'b1; rsv_addr = 6'd20; tick();
    #1 chk("r20_cnt", {57'd0, busy_cnt}, 64'd1);
    ra0 = 6'd5; ra1 = 6'd20;
    #1 rstn = 1'b0;
    #1 chk("arst_rdata", {rdata[63:32], rdata[31:0]}, 64'd0);
    chk("arst_ready", {62'd0, rready}, {62'd0, 2'b11});
    chk("arst_cnt", {57'd0, busy_cnt}, 64'd0);
    chk("arst_stall", {63'd0, rsv_stall}, 64'd0);
    idle();
    tick();
    rstn = 1'b1;
    tick();
    ra1 = 6'd12;
    #1 chk("post_rst_r12", {32'd0, rdata[63:32]}, 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
